adda_pll_supervisor: RTL and testbench

Sequencing controller for the ADDA clocking PLL, running on the free-running init clock. It drives the PLL reset, waits for lock with a timeout and bounded retries, and debounces lock before releasing the ADC/DAC datapath. It monitors lock loss in operation and re-sequences the PLL when lock drops. It sits beside the ADDA PLL wrapper, and its `adda_ready` gates the ADDA-domain reset synchronisers.

---
 rtl/adda_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 34 +++
 rtl/adda_pll_supervisor.sv | 177 +++++++++++++++++
 tb/tb_adda_pll_supervisor.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adda_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adda_pkg
//  Purpose  : Shared definitions for the ADDA clocking blocks: the PLL
//             supervisor state encoding and default timing constants.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package adda_pkg;

   // Encodings are visible on the supervisor's state output, so keep them fixed.
   typedef enum logic [2:0] {
      ST_RESET_PLL = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAULT     = 3'd4
   } adda_pll_state_e;

   // Init clock is 50 MHz; 50000 cycles gives a 1 ms lock window.
   localparam int ADDA_INIT_CLK_PERIOD_NS = 20;
   localparam int ADDA_PLL_LOCK_TIMEOUT   = 1000000 / ADDA_INIT_CLK_PERIOD_NS;

endpackage : adda_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : Single-bit two-flop synchroniser, reset to 0.
//  Ports    : clk - destination clock
//             rst - asynchronous active-high reset
//             d   - asynchronous input
//             q   - synchronised output (2 cycles of latency)
//  Revision : 1.0 - initial release
// ============================================================================
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/adda_pll_supervisor.sv
`default_nettype none
// ============================================================================
//  Module   : adda_pll_supervisor
//  Purpose  : Sequences the ADDA PLL: holds it in reset, waits for lock with
//             timeout and bounded retries, debounces lock before releasing
//             the ADC/DAC datapath, and re-sequences on lock loss in RUN.
//  Ports    : init_clk   - free-running controller clock
//             reset      - asynchronous active-high reset
//             pll_lock   - raw PLL lock (asynchronous)
//             restart    - one-cycle pulse forcing a fresh sequence
//             pll_rst    - PLL reset, active high
//             adda_ready - high only in RUN
//             fault      - high only in FAULT
//             state      - current state encoding
//             retry_cnt  - failed attempts since last RUN or restart
//             loss_cnt   - lock losses seen in RUN, saturating at 255
//  Revision : 1.0 - initial release
// ============================================================================
module adda_pll_supervisor
   import adda_pkg::*;
#(
   parameter int RST_CYCLES    = 64,
   parameter int LOCK_TIMEOUT  = ADDA_PLL_LOCK_TIMEOUT,
   parameter int STABLE_CYCLES = 1024,
   parameter int LOSS_FILTER   = 4,
   parameter int MAX_RETRIES   = 7,
   parameter int CNT_W         = 16
) (
   input  logic       init_clk,
   input  logic       reset,
   input  logic       pll_lock,
   input  logic       restart,
   output logic       pll_rst,
   output logic       adda_ready,
   output logic       fault,
   output logic [2:0] state,
   output logic [2:0] retry_cnt,
   output logic [7:0] loss_cnt
);

   // Terminal counts: a transition fires on the edge where the timer holds N-1.
   localparam logic [CNT_W-1:0] c_rst_last    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] c_stable_last = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_loss_last   = CNT_W'(LOSS_FILTER - 1);
   localparam logic [2:0]       c_max_retries = 3'(MAX_RETRIES);

   logic lock_s;

   adda_pll_state_e  state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0] low_run_q, low_run_d;
   logic [2:0]       retry_q, retry_d;
   logic [7:0]       loss_cnt_q, loss_cnt_d;
   logic             pll_rst_q, pll_rst_d;
   logic             adda_ready_q, adda_ready_d;
   logic             fault_q, fault_d;

   sync_2ff u_lock_sync (
      .clk (init_clk),
      .rst (reset),
      .d   (pll_lock),
      .q   (lock_s)
   );

   // State register, counters and registered output decodes.
   always_ff @(posedge init_clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_RESET_PLL;
         timer_q      <= '0;
         low_run_q    <= '0;
         retry_q      <= '0;
         loss_cnt_q   <= '0;
         pll_rst_q    <= 1'b1;
         adda_ready_q <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         low_run_q    <= low_run_d;
         retry_q      <= retry_d;
         loss_cnt_q   <= loss_cnt_d;
         pll_rst_q    <= pll_rst_d;
         adda_ready_q <= adda_ready_d;
         fault_q      <= fault_d;
      end
   end

   // Next-state and counter logic.
   always_comb begin
      state_d    = state_q;
      retry_d    = retry_q;
      loss_cnt_d = loss_cnt_q;
      low_run_d  = '0;

      case (state_q)
         ST_RESET_PLL: begin
            if (timer_q == c_rst_last) begin
               state_d = ST_WAIT_LOCK;
            end
         end
         ST_WAIT_LOCK: begin
            if (lock_s) begin
               state_d = ST_STABLE;
            end else if (timer_q == c_timeout_last) begin
               if (retry_q == c_max_retries) begin
                  state_d = ST_FAULT;
               end else begin
                  retry_d = retry_q + 3'd1;
                  state_d = ST_RESET_PLL;
               end
            end
         end
         ST_STABLE: begin
            // A lock drop restarts the debounce window but is not a failed attempt.
            if (!lock_s) begin
               state_d = ST_WAIT_LOCK;
            end else if (timer_q == c_stable_last) begin
               state_d = ST_RUN;
               retry_d = '0;
            end
         end
         ST_RUN: begin
            // low_run_q counts consecutive low cycles already seen; this cycle
            // is the LOSS_FILTER-th when it equals LOSS_FILTER-1.
            if (!lock_s) begin
               if (low_run_q == c_loss_last) begin
                  state_d    = ST_RESET_PLL;
                  loss_cnt_d = (loss_cnt_q == 8'hFF) ? loss_cnt_q : loss_cnt_q + 8'd1;
               end else begin
                  low_run_d = low_run_q + 1'b1;
               end
            end
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_RESET_PLL;
         end
      endcase

      // Restart overrides any lock-loss or timeout decision in the same cycle.
      if (restart) begin
         state_d    = ST_RESET_PLL;
         retry_d    = '0;
         loss_cnt_d = loss_cnt_q;
         low_run_d  = '0;
      end

      // Shared timer: cleared on every state entry (a restart counts as one),
      // otherwise counts up and parks at all-ones in long-lived states.
      if (restart || (state_d != state_q)) begin
         timer_d = '0;
      end else if (timer_q == {CNT_W{1'b1}}) begin
         timer_d = timer_q;
      end else begin
         timer_d = timer_q + 1'b1;
      end
   end

   // Outputs are decodes of the next state so they change on the entry edge.
   always_comb begin
      pll_rst_d    = (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
      adda_ready_d = (state_d == ST_RUN);
      fault_d      = (state_d == ST_FAULT);
   end

   assign pll_rst    = pll_rst_q;
   assign adda_ready = adda_ready_q;
   assign fault      = fault_q;
   assign state      = state_q;
   assign retry_cnt  = retry_q;
   assign loss_cnt   = loss_cnt_q;

endmodule : adda_pll_supervisor
`default_nettype wire

// File: tb/tb_adda_pll_supervisor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adda_pll_supervisor
//  Purpose  : Directed self-checking bench for adda_pll_supervisor using
//             small timing parameters (4/20/8/3/2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adda_pll_supervisor;

   logic       clk;
   logic       reset;
   logic       pll_lock;
   logic       restart;
   logic       pll_rst;
   logic       adda_ready;
   logic       fault;
   logic [2:0] state;
   logic [2:0] retry_cnt;
   logic [7:0] loss_cnt;

   int n_cmp;
   int n_bad;

   // Observed vector: {state, pll_rst, adda_ready, fault, retry_cnt, loss_cnt}
   logic [16:0] obs;
   logic [16:0] exp_v;
   assign obs = {state, pll_rst, adda_ready, fault, retry_cnt, loss_cnt};

   adda_pll_supervisor #(
      .RST_CYCLES    (4),
      .LOCK_TIMEOUT  (20),
      .STABLE_CYCLES (8),
      .LOSS_FILTER   (3),
      .MAX_RETRIES   (2),
      .CNT_W         (16)
   ) dut (
      .init_clk   (clk),
      .reset      (reset),
      .pll_lock   (pll_lock),
      .restart    (restart),
      .pll_rst    (pll_rst),
      .adda_ready (adda_ready),
      .fault      (fault),
      .state      (state),
      .retry_cnt  (retry_cnt),
      .loss_cnt   (loss_cnt)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Expected output vector for a given state: pll_rst in RESET_PLL/FAULT,
   // adda_ready in RUN, fault in FAULT.
   function automatic logic [16:0] exp_vec(input logic [2:0] st,
                                           input logic [2:0] rc,
                                           input logic [7:0] lc);
      logic pr, rd, fl;
      pr = (st == 3'd0) || (st == 3'd4);
      rd = (st == 3'd3);
      fl = (st == 3'd4);
      return {st, pr, rd, fl, rc, lc};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      pll_lock = 1'b0;
      restart  = 1'b0;
      tick();
      tick();
      exp_v = exp_vec(3'd0, 3'd0, 8'd0);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL reset_state: got %h want %h", obs, exp_v);
      end
   endtask

   // Release reset, raise pll_lock 5 edges later, expect RUN at edge 16.
   task automatic test_bring_up();
      logic [2:0] st;
      reset = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         st = (i <= 3) ? 3'd0 : (i <= 7) ? 3'd1 : (i <= 15) ? 3'd2 : 3'd3;
         exp_v = exp_vec(st, 3'd0, 8'd0);
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL bring_up edge %0d: got %h want %h", i, obs, exp_v);
         end
         if (i == 5) pll_lock = 1'b1;
      end
   endtask

   task automatic test_loss_filter();
      logic [2:0] st;
      logic [7:0] lc;
      // 2-cycle low: filtered out.
      pll_lock = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 2) pll_lock = 1'b1;
         exp_v = exp_vec(3'd3, 3'd0, 8'd0);
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL loss_short edge %0d: got %h want %h", i, obs, exp_v);
         end
      end
      // 3-cycle low: real loss, then relock back to RUN.
      pll_lock = 1'b0;
      for (int i = 1; i <= 18; i++) begin
         tick();
         if (i == 3) pll_lock = 1'b1;
         st = (i <= 4) ? 3'd3 : (i <= 8) ? 3'd0 : (i == 9) ? 3'd1 : (i <= 17) ? 3'd2 : 3'd3;
         lc = (i <= 4) ? 8'd0 : 8'd1;
         exp_v = exp_vec(st, 3'd0, lc);
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL loss_real edge %0d: got %h want %h", i, obs, exp_v);
         end
      end
   endtask

   // Restart from RUN, then a 1-cycle lock glitch at STABLE count 5.
   task automatic test_chatter();
      logic [2:0] st;
      restart = 1'b1;
      for (int i = 1; i <= 23; i++) begin
         tick();
         if (i == 1) restart = 1'b0;
         if (i == 11) pll_lock = 1'b0;
         if (i == 12) pll_lock = 1'b1;
         st = (i <= 4) ? 3'd0 : (i == 5) ? 3'd1 : (i <= 13) ? 3'd2 :
              (i == 14) ? 3'd1 : (i <= 22) ? 3'd2 : 3'd3;
         exp_v = exp_vec(st, 3'd0, 8'd1);
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL chatter edge %0d: got %h want %h", i, obs, exp_v);
         end
      end
   endtask

   // Restart coincides with the 3rd lock-low cycle in RUN: no loss counted.
   task automatic test_restart_on_loss();
      logic [2:0] st;
      pll_lock = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         if (i == 4) restart = 1'b1;
         if (i == 5) restart = 1'b0;
         st = (i <= 4) ? 3'd3 : 3'd0;
         exp_v = exp_vec(st, 3'd0, 8'd1);
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL restart_on_loss edge %0d: got %h want %h", i, obs, exp_v);
         end
      end
   endtask

   // Starts just after a RESET_PLL entry with lock low. Each attempt is
   // 4 + 20 = 24 cycles; third timeout at edge 72 enters FAULT.
   task automatic test_timeout();
      logic [2:0] st;
      logic [2:0] rc;
      for (int i = 1; i <= 72; i++) begin
         tick();
         if (i == 72) begin
            st = 3'd4;
            rc = 3'd2;
         end else begin
            st = ((i % 24) < 4) ? 3'd0 : 3'd1;
            rc = 3'(i / 24);
         end
         exp_v = exp_vec(st, rc, 8'd1);
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL timeout edge %0d: got %h want %h", i, obs, exp_v);
         end
      end
      for (int i = 1; i <= 110; i++) begin
         tick();
         exp_v = exp_vec(3'd4, 3'd2, 8'd1);
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL fault_hold cycle %0d: got %h want %h", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_restart_from_fault();
      restart = 1'b1;
      tick();
      restart = 1'b0;
      exp_v = exp_vec(3'd0, 3'd0, 8'd1);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL restart_from_fault: got %h want %h", obs, exp_v);
      end
   endtask

   // Reach STABLE, assert reset between edges, expect reset values at once.
   task automatic test_async_reset();
      logic [2:0] st;
      restart  = 1'b1;
      pll_lock = 1'b1;
      tick();
      restart = 1'b0;
      for (int i = 2; i <= 7; i++) tick();
      exp_v = exp_vec(3'd2, 3'd0, 8'd1);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL pre_reset_stable: got %h want %h", obs, exp_v);
      end
      #5;
      reset = 1'b1;
      #1;
      exp_v = exp_vec(3'd0, 3'd0, 8'd0);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL async_reset: got %h want %h", obs, exp_v);
      end
      tick();
      reset = 1'b0;
      // Synchroniser was cleared too, so lock_s reappears 2 edges later.
      for (int i = 1; i <= 5; i++) begin
         tick();
         st = (i <= 3) ? 3'd0 : (i == 4) ? 3'd1 : 3'd2;
         exp_v = exp_vec(st, 3'd0, 8'd0);
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL post_reset edge %0d: got %h want %h", i, obs, exp_v);
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_bring_up();
      test_loss_filter();
      test_chatter();
      test_restart_on_loss();
      test_timeout();
      test_restart_from_fault();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

endmodule : tb_adda_pll_supervisor
`default_nettype wire
